// File: rtl/i2s_async_src.sv
// i2s_async_src: source half of the I2S async-data CDC.
// Buffers producer words in a small FIFO and presents them one at a time on
// data_out, framed by a 4-phase req/ack handshake. The ack comes from the
// destination clock domain and is brought in through a flop synchroniser.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   data_in         word from local producer
//   data_in_valid   producer has a word
//   data_in_ready   FIFO can accept (push = valid & ready)
//   data_out        CDC data, stable whenever data_out_req=1
//   data_out_req    CDC request (registered)
//   data_out_ack    async ack from destination
//   fifo_level      words buffered, excluding the word in flight
//   busy            FSM not idle or FIFO not empty
module i2s_async_src #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     data_in_valid,
  output logic                     data_in_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_out_req,
  input  logic                     data_out_ack,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(SYNC_STAGES + 1) + 1;

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_REQ,
    ST_WAIT_LOW
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic             ack_s;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             req_q, req_d;
  logic             push, pop;

  // Ack synchroniser
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], data_out_ack};
  end
  assign ack_s = sync_q[SYNC_STAGES-1];

  // FIFO: ready depends only on registered level, so a pop in the same cycle
  // does not open a slot early.
  assign data_in_ready = (level_q < LW'(DEPTH)) && (state_q != ST_FLUSH);
  assign push          = data_in_valid && data_in_ready;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_in;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  // Handshake FSM. FLUSH waits until the synchroniser has been refilled with
  // the real ack level, then parks in WAIT_LOW so a stale high ack held by the
  // destination across our reset is drained before any new request.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    dout_d      = dout_q;
    req_d       = req_q;
    pop         = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == CW'(SYNC_STAGES)) begin
          state_d = ST_WAIT_LOW;
        end else begin
          flush_cnt_d = flush_cnt_q + CW'(1);
        end
      end
      ST_IDLE: begin
        if ((level_q != '0) && !ack_s) begin
          pop     = 1'b1;
          dout_d  = mem_q[rd_ptr_q];
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!ack_s) begin
          if (level_q != '0) begin
            pop     = 1'b1;
            dout_d  = mem_q[rd_ptr_q];
            req_d   = 1'b1;
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      sync_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      dout_q      <= '0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      sync_q      <= sync_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      dout_q      <= dout_d;
      req_q       <= req_d;
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_out     = dout_q;
  assign data_out_req = req_q;
  assign fifo_level   = level_q;
  assign busy         = (state_q != ST_IDLE) || (level_q != '0);

endmodule
